// File: rtl/clock_control_pkg.sv
// Shared types and constants for the root clock-domain controller.
package clock_control_pkg;

  typedef enum logic [1:0] {
    CC_SILENT,
    CC_STARTING,
    CC_READY,
    CC_STOPPING
  } cc_state_e;

  localparam int CC_WAKE_CNT_W = 16;

  // Largest of three window lengths; sizes the shared timer width.
  function automatic int cc_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/clock_control_timer.sv
// Loadable down-counter that holds at zero; zero flag is combinational.
module clock_control_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // Load wins over decrement; decrement stops at zero.
  always_ff @(posedge clk) begin
    if (rst)                      cnt_q <= '0;
    else if (load)                cnt_q <= load_val;
    else if (dec && cnt_q != '0)  cnt_q <= cnt_q - 1'b1;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/clock_control_root.sv
// Root clock-domain controller: sequences SILENT/STARTING/READY/STOPPING,
// drives the clock-gate enable and counts wake-ups.
module clock_control_root
  import clock_control_pkg::*;
#(
  parameter int START_CYCLES   = 4,
  parameter int STOP_CYCLES    = 4,
  parameter int MIN_OFF_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     request,
  input  logic                     force_on,
  output logic                     ready,
  output logic                     silent,
  output logic                     starting,
  output logic                     stopping,
  output logic                     clk_en,
  output logic [CC_WAKE_CNT_W-1:0] wake_count
);

  localparam int CNT_W = $clog2(cc_max3(START_CYCLES, STOP_CYCLES, MIN_OFF_CYCLES) + 1);
  localparam logic [CNT_W-1:0] START_LD = CNT_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] STOP_LD  = CNT_W'(STOP_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LD   = CNT_W'(MIN_OFF_CYCLES);

  cc_state_e                state_q, state_d;
  logic                     silent_q, starting_q, ready_q, stopping_q, clk_en_q;
  logic [CC_WAKE_CNT_W-1:0] wake_q;

  logic             req_eff;
  logic             win_load, win_dec, win_zero;
  logic [CNT_W-1:0] win_val;
  logic             off_load, off_dec, off_zero;
  logic             wake_inc;

  // All requesters share clk, so the request is used unsynchronized.
  assign req_eff = request | force_on;

  // Start/stop window timer: only counts in the two timed states.
  assign win_dec = (state_q == CC_STARTING) || (state_q == CC_STOPPING);
  clock_control_timer #(.W(CNT_W)) u_win (
    .clk(clk), .rst(rst), .load(win_load), .load_val(win_val),
    .dec(win_dec), .zero(win_zero)
  );

  // Off-hold timer: enforces a minimum gated-off time after a stop.
  assign off_dec = (state_q == CC_SILENT);
  clock_control_timer #(.W(CNT_W)) u_off (
    .clk(clk), .rst(rst), .load(off_load), .load_val(OFF_LD),
    .dec(off_dec), .zero(off_zero)
  );

  // Next-state and timer-load decode; STARTING and STOPPING ignore requests
  // until their window expires.
  always_comb begin
    state_d  = state_q;
    win_load = 1'b0;
    win_val  = '0;
    off_load = 1'b0;
    wake_inc = 1'b0;
    unique case (state_q)
      CC_SILENT: if (off_zero && req_eff) begin
        state_d  = CC_STARTING;
        win_load = 1'b1;
        win_val  = START_LD;
        wake_inc = 1'b1;
      end
      CC_STARTING: if (win_zero) begin
        if (req_eff) state_d = CC_READY;
        else begin
          state_d  = CC_STOPPING;
          win_load = 1'b1;
          win_val  = STOP_LD;
        end
      end
      CC_READY: if (!req_eff) begin
        state_d  = CC_STOPPING;
        win_load = 1'b1;
        win_val  = STOP_LD;
      end
      CC_STOPPING: if (win_zero) begin
        state_d  = CC_SILENT;
        off_load = 1'b1;
      end
      default: state_d = CC_SILENT;
    endcase
  end

  // State register with status and gate enable registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CC_SILENT;
      silent_q   <= 1'b1;
      starting_q <= 1'b0;
      ready_q    <= 1'b0;
      stopping_q <= 1'b0;
      clk_en_q   <= 1'b0;
      wake_q     <= '0;
    end else begin
      state_q    <= state_d;
      silent_q   <= (state_d == CC_SILENT);
      starting_q <= (state_d == CC_STARTING);
      ready_q    <= (state_d == CC_READY);
      stopping_q <= (state_d == CC_STOPPING);
      clk_en_q   <= (state_d != CC_SILENT);
      if (wake_inc && wake_q != '1) wake_q <= wake_q + 1'b1;
    end
  end

  assign silent     = silent_q;
  assign starting   = starting_q;
  assign ready      = ready_q;
  assign stopping   = stopping_q;
  assign clk_en     = clk_en_q;
  assign wake_count = wake_q;

endmodule

// File: tb/tb_clock_control_root.sv
// Bench for clock_control_root: directed scenarios plus randomized traffic,
// all checked each cycle against a duration-based reference model.
module tb_clock_control_root;

  localparam int START = 4;
  localparam int STOP  = 3;
  localparam int MOFF  = 2;

  logic        clk = 1'b0;
  logic        rst, request, force_on;
  logic        ready, silent, starting, stopping, clk_en;
  logic [15:0] wake_count;

  clock_control_root #(.START_CYCLES(START), .STOP_CYCLES(STOP), .MIN_OFF_CYCLES(MOFF)) dut (
    .clk(clk), .rst(rst), .request(request), .force_on(force_on),
    .ready(ready), .silent(silent), .starting(starting), .stopping(stopping),
    .clk_en(clk_en), .wake_count(wake_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_on = 0;
  int n_start, n_ready, n_stop, n_en;

  // Reference model: phase plus time spent in it (0=off,1=warm,2=on,3=drain).
  int          m_ph, m_age, m_need;
  logic [15:0] m_wake;

  task automatic model_step(input logic r, input logic f, input logic q);
    bit req;
    req = r | f;
    if (q) begin
      m_ph = 0; m_age = 0; m_need = 0; m_wake = 16'd0;
    end else if (m_ph == 0) begin
      if (req && m_age >= m_need) begin
        m_ph = 1; m_age = 0;
        if (m_wake != 16'hFFFF) m_wake = m_wake + 16'd1;
      end else m_age++;
    end else if (m_ph == 1) begin
      if (m_age >= START - 1) begin m_ph = req ? 2 : 3; m_age = 0; end
      else m_age++;
    end else if (m_ph == 2) begin
      if (!req) begin m_ph = 3; m_age = 0; end
    end else begin
      if (m_age >= STOP - 1) begin m_ph = 0; m_age = 0; m_need = MOFF; end
      else m_age++;
    end
  endtask

  function automatic logic [20:0] mdl_v();
    return {m_ph == 0, m_ph == 1, m_ph == 2, m_ph == 3, m_ph != 0, m_wake};
  endfunction

  function automatic logic [20:0] dut_v();
    return {silent, starting, ready, stopping, clk_en, wake_count};
  endfunction

  // Drive one cycle from a negedge, advance the model, sample at next negedge.
  task automatic step(input logic r, input logic f, input logic q);
    request = r; force_on = f; rst = q;
    model_step(r, f, q);
    @(posedge clk);
    @(negedge clk);
    n_start += int'(starting); n_ready += int'(ready);
    n_stop  += int'(stopping); n_en    += int'(clk_en);
  endtask

  task automatic clr_tally();
    n_start = 0; n_ready = 0; n_stop = 0; n_en = 0;
  endtask

  always @(negedge clk)
    if (chk_on)
      assert ($onehot({silent, starting, ready, stopping}))
      else $error("one-hot status violated at %0t", $time);

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1);
      tests++;
      if ({silent, clk_en, starting} !== 3'b100 || dut_v() !== mdl_v()) begin
        fails++; $display("FAIL reset_hold i=%0d got=%h exp=%h", i, dut_v(), mdl_v());
      end
    end
    chk_on = 1;
    step(1, 0, 0);
    tests++;
    if (starting !== 1'b1 || clk_en !== 1'b1 || wake_count !== 16'd1) begin
      fails++; $display("FAIL reset_release got=%h exp starting=1 clk_en=1 wake=1", dut_v());
    end
  endtask

  task automatic test_full_cycle();
    step(0, 0, 1);
    clr_tally();
    for (int i = 0; i < 31; i++) begin
      step((i >= 3 && i < 23) ? 1'b1 : 1'b0, 0, 0);
      tests++;
      if (dut_v() !== mdl_v()) begin
        fails++; $display("FAIL full_cycle i=%0d got=%h exp=%h", i, dut_v(), mdl_v());
      end
    end
    tests++;
    if (n_start !== 4 || n_ready !== 16 || n_stop !== 3 || n_en !== 23 ||
        silent !== 1'b1 || wake_count !== 16'd1) begin
      fails++;
      $display("FAIL full_cycle_counts got st=%0d rdy=%0d sp=%0d en=%0d wake=%0d exp 4 16 3 23 1",
               n_start, n_ready, n_stop, n_en, wake_count);
    end
  endtask

  task automatic test_pulse();
    step(0, 0, 1);
    clr_tally();
    for (int i = 0; i < 12; i++) begin
      step(i == 0, 0, 0);
      tests++;
      if (dut_v() !== mdl_v()) begin
        fails++; $display("FAIL pulse i=%0d got=%h exp=%h", i, dut_v(), mdl_v());
      end
    end
    tests++;
    if (n_start !== START || n_ready !== 0 || n_stop !== STOP || silent !== 1'b1) begin
      fails++;
      $display("FAIL pulse_counts got st=%0d rdy=%0d sp=%0d sil=%0b exp 4 0 3 1",
               n_start, n_ready, n_stop, silent);
    end
  endtask

  task automatic test_rerequest();
    int sil;
    bit seen;
    step(0, 0, 1);
    for (int i = 0; i < 7; i++) step(i != 5, 0, 0);  // ready, then stop, re-request at 2nd stop cycle
    tests++;
    if (stopping !== 1'b1 || dut_v() !== mdl_v()) begin
      fails++; $display("FAIL rereq_in_stop got=%h exp=%h", dut_v(), mdl_v());
    end
    sil = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1, 0, 0);
      sil += int'(silent);
      seen = starting;
      tests++;
      if (dut_v() !== mdl_v()) begin
        fails++; $display("FAIL rereq i=%0d got=%h exp=%h", i, dut_v(), mdl_v());
      end
    end
    tests++;
    if (!seen || sil !== MOFF + 1 || wake_count !== 16'd2) begin
      fails++; $display("FAIL rereq_gap got silent=%0d wake=%0d restarted=%0b exp 3 2 1", sil, wake_count, seen);
    end
  endtask

  task automatic test_force();
    step(0, 0, 1);
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 0);
      tests++;
      if (dut_v() !== mdl_v() || (i >= START && ready !== 1'b1)) begin
        fails++; $display("FAIL force i=%0d got=%h exp=%h", i, dut_v(), mdl_v());
      end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] exp_w [3];
    exp_w[0] = 16'hFFFE; exp_w[1] = 16'hFFFF; exp_w[2] = 16'hFFFF;
    step(0, 0, 1);
    force dut.wake_q = 16'hFFFD;
    #1 release dut.wake_q;
    m_wake = 16'hFFFD;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 11; i++) begin
        step(0, i == 0, 0);
        tests++;
        if (dut_v() !== mdl_v()) begin
          fails++; $display("FAIL sat k=%0d i=%0d got=%h exp=%h", k, i, dut_v(), mdl_v());
        end
      end
      tests++;
      if (wake_count !== exp_w[k]) begin
        fails++; $display("FAIL sat_value k=%0d got=%h exp=%h", k, wake_count, exp_w[k]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    step(0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 0);
    tests++;
    if (ready !== 1'b1) begin fails++; $display("FAIL mid_pre_ready got=%b exp=1", ready); end
    step(1, 0, 1);
    tests++;
    if ({silent, clk_en, wake_count} !== {2'b10, 16'd0}) begin
      fails++; $display("FAIL mid_rst_ready got=%h exp=%h", dut_v(), mdl_v());
    end
    for (int i = 0; i < 6; i++) step(1, 0, 0);
    step(0, 0, 0); step(0, 0, 0);
    tests++;
    if (stopping !== 1'b1) begin fails++; $display("FAIL mid_pre_stop got=%b exp=1", stopping); end
    step(0, 0, 1);
    tests++;
    if ({silent, clk_en} !== 2'b10 || dut_v() !== mdl_v()) begin
      fails++; $display("FAIL mid_rst_stop got=%h exp=%h", dut_v(), mdl_v());
    end
    step(1, 0, 0);
    tests++;
    if (starting !== 1'b1 || dut_v() !== mdl_v()) begin
      fails++; $display("FAIL mid_restart got=%h exp=%h", dut_v(), mdl_v());
    end
  endtask

  task automatic test_random();
    logic r, f;
    r = 0; f = 0;
    step(0, 0, 1);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 6) == 0)  r = ~r;
      if ($urandom_range(0, 40) == 0) f = ~f;
      step(r, f, $urandom_range(0, 199) == 0);
      tests++;
      if (dut_v() !== mdl_v()) begin
        fails++; $display("FAIL random i=%0d got=%h exp=%h", i, dut_v(), mdl_v());
      end
    end
  endtask

  initial begin
    rst = 1'b1; request = 1'b0; force_on = 1'b0;
    @(negedge clk);
    test_reset();
    test_full_cycle();
    test_pulse();
    test_rerequest();
    test_force();
    test_saturation();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clock_control_root.md
# clock_control_root

Root clock-domain controller: turns the aggregated request from the clock-control fan-out tree into the registered silent/starting/ready/stopping status, and drives the enable of the domain's clock gate. It sits directly upstream of the duplicating fan-out stage. It consumes that stage's `parent_request` and produces the `parent_ready/silent/starting/stopping` it distributes. Start and stop phases are timed windows so the gate and downstream logic settle before `ready` and after `request` drops.

## Interface
- `START_CYCLES`, default 4, cycles spent in STARTING with clock enabled before `ready`; must be ≥1.
- `STOP_CYCLES`, default 4, cycles the clock stays enabled in STOPPING to drain; must be ≥1.
- `MIN_OFF_CYCLES`, default 2, minimum cycles in SILENT after a stop before a new start; may be 0.
- `clk` in 1: single clock. Everything is in this domain.
- `rst` in 1: reset, **synchronous, active-high**.
- `request` in 1: aggregated child request. Level-sensitive.
- `force_on` in 1: debug override, OR-ed with `request`.
- `ready` out 1: clock running and stable.
- `silent` out 1: clock gated off.
- `starting` out 1: clock enabled, settling.
- `stopping` out 1: clock enabled, draining.
- `clk_en` out 1: clock-gate enable.
- `wake_count` out 16: number of SILENT→STARTING transitions. Saturates at 16'hFFFF.

## Operation
- `req_eff = request | force_on`. It is sampled every rising edge. There is no input synchronizer, because all requesters are in the `clk` domain.
- The FSM has four states. Status outputs are registered and one-hot: exactly one of `silent/starting/ready/stopping` is high every cycle.
- `clk_en` is 1 in STARTING, READY and STOPPING, and 0 in SILENT. It is registered and decoded from the next state.
- **SILENT**
  - If the off-hold counter is 0 and `req_eff`=1, go to STARTING.
  - On that transition, load the timer with START_CYCLES−1 and increment `wake_count` (saturating).
- **STARTING**
  - This state is uninterruptible.
  - When the timer reaches 0: if `req_eff`=1, go to READY. Otherwise go directly to STOPPING and load STOP_CYCLES−1.
- **READY**
  - Stay while `req_eff`=1.
  - When `req_eff`=0, go to STOPPING and load STOP_CYCLES−1.
- **STOPPING**
  - This state is uninterruptible; a request arriving mid-stop is ignored.
  - When the timer reaches 0, go to SILENT and load the off-hold counter with MIN_OFF_CYCLES.
- **Off-hold counter**
  - Decrements in SILENT while nonzero.
  - A `req_eff` held high is honoured as soon as the counter reaches 0. With MIN_OFF_CYCLES=0 there is exactly one SILENT cycle between STOPPING and STARTING.
- **Counter width:** `CNT_W = $clog2(max(START_CYCLES, STOP_CYCLES, MIN_OFF_CYCLES)+1)`.

## Timing
- **Reset values:** SILENT, `silent`=1, `starting`=`ready`=`stopping`=0, `clk_en`=0, timer=0, off-hold=0 (an immediate start after reset is allowed), `wake_count`=0.
- **Reset mid-operation:** the block returns to the reset state on the next edge regardless of the current state, and `clk_en` drops in that same cycle.
- **Start timing:** `req_eff` sampled high at edge N in SILENT gives `starting`=1 and `clk_en`=1 after edge N. `ready`=1 follows after edge N+START_CYCLES.
- **Stop timing:** `req_eff` sampled low at edge M in READY gives `stopping`=1 after edge M. `silent`=1 and `clk_en`=0 follow after edge M+STOP_CYCLES.
- **Minimum restart time:** after `silent` rises, the earliest next `starting` is MIN_OFF_CYCLES+1 cycles later.
- **Short pulses:** a one-cycle `req_eff` pulse in SILENT still produces a full STARTING (START_CYCLES) followed by a full STOPPING (STOP_CYCLES), with no READY cycle.
- **Saturation:** `wake_count` at 16'hFFFF stays at 16'hFFFF.

## Structure
- Shared package `clock_control_pkg` holds:
  - enum `cc_state_e` with values {CC_SILENT, CC_STARTING, CC_READY, CC_STOPPING};
  - the constant `CC_WAKE_CNT_W` = 16.
- One sub-module, `clock_control_timer`: a parameterized-width down-counter with `load`, `load_val`, `dec`, and a `zero` output. It is instantiated once for the start/stop window and once for the off-hold.

## Test plan
Parameters for all scenarios: START=4, STOP=3, MIN_OFF=2.
- **Reset:** hold `rst` for 3 cycles with `request`=1 → `silent`=1, `clk_en`=0 throughout; `starting`=1 on the first cycle after `rst` falls.
- **Full cycle:** raise `request` at edge 10 and drop it at edge 30 → `starting` on edges 11–14, `ready` on 15–30, `stopping` on 31–33, `silent` from 34; `clk_en`=1 on edges 11–33; `wake_count`=1.
- **Pulse during start:** a one-cycle `request` at edge 10 → 4 cycles STARTING, then 3 cycles STOPPING, no `ready`, then `silent`.
- **Re-request during stop:** `request` reasserted in the middle of STOPPING and held → STOPPING completes, SILENT lasts exactly 3 cycles, then STARTING; `wake_count` increments.
- **Force and saturation:** `force_on`=1 with `request`=0 → reaches READY and holds. Separately, preload `wake_count` near saturation via repeated wakes (or a forced bench value) → it stops at 16'hFFFF.
- **Reset mid-run:** assert `rst` during READY and during STOPPING → `silent`=1 and `clk_en`=0 on the next cycle; the one-hot invariant is checked every cycle by an assertion.
